matrix_alu_param: RTL and testbench
===================================

Name: matrix_alu_param

Overview:
Parametrised N x N signed matrix ALU, the successor to the fixed 3x3 sel-driven matrix ALU. Holds operand matrices A and B plus result matrix R in internal registers, with separate write, command and read ports. Runs transpose, add, subtract, scalar multiply and matrix multiply under a start/busy/done handshake. Matrix multiply is sequential, using one MAC per cycle.

Parameters:
N, 3, matrix dimension; legal 2..4.
W, 32, element width in bits, signed two's complement; legal 8..32.
AW, 4, element address width; must satisfy 2^AW >= N*N.

Ports:
clk  input  1  system clock; all state changes on rising edge.
reset_n  input  1  asynchronous active-low reset.
wr_en  input  1  write strobe for one operand element.
wr_sel  input  1  0 = write A, 1 = write B.
wr_addr  input  AW  row-major element index (row*N + col).
wr_data  input  W  element value.
op_start  input  1  command strobe, sampled only in IDLE.
op_code  input  3  0 = R=A', 1 = R=A+B, 2 = R=A-B, 3 = R=A*B, 4 = R=k*A; 5..7 illegal.
scalar  input  W  k for op 4; latched at op_start.
rd_addr  input  AW  R element index.
rd_data  output  W  registered R element.
busy  output  1  high while an operation executes.
done  output  1  one-cycle completion pulse.
err  output  1  sticky illegal-op flag.
ovf  output  1  sticky overflow flag; functional only with the optional feature.

Behaviour:
- Reset (async, reset_n=0):
  - A, B, R cleared to 0.
  - busy, done, err, ovf, rd_data all 0.
  - FSM forced to IDLE; any operation in progress is aborted with no done pulse.
- Writes:
  - Accepted in IDLE when wr_en=1 and wr_addr < N*N.
  - Out-of-range address or a write during RUN/DONE is silently dropped; A and B stay unchanged.
- Read:
  - rd_data <= R[rd_addr] on every edge, so data appears one cycle after the address.
  - rd_addr >= N*N returns 0.
  - Reads are legal during RUN and return the current, partially updated R.
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN on op_start with a legal op_code. On this edge: op, scalar and counters are latched; err and ovf are cleared.
  - IDLE -> DONE on op_start with an illegal op_code. R is unchanged and err is set.
  - RUN -> DONE when the last element is written.
  - DONE -> IDLE unconditionally after one cycle.
  - busy = (state == RUN); done = (state == DONE).
  - op_start while busy or in DONE is ignored.
- Element-wise ops (0, 1, 2, 4):
  - One R element per RUN cycle, index 0..N*N-1 ascending.
  - RUN lasts exactly N*N cycles. With op_start sampled at edge 0, done is high during cycle N*N+1.
  - Transpose: R[i][j] = A[j][i].
- Multiply (op 3):
  - Counters i, j, k; k is innermost.
  - acc cleared at k=0; acc += A[i][k]*B[k][j] each cycle; R[i][j] written when k=N-1.
  - RUN lasts exactly N^3 cycles (27 for N=3).
- Arithmetic:
  - All signed, W-bit.
  - Each product is truncated to W bits and the accumulator wraps modulo 2^W, unless SATURATE_EN is defined.
  - A and B are never modified by any operation.

Optional Feature:
- Macro: MATRIX_ALU_SATURATE_EN.
- Defined:
  - Every add, subtract, product and accumulator step is clamped to [-2^(W-1), 2^(W-1)-1].
  - Any clamp sets ovf, which stays set until the next accepted op_start.
- Undefined:
  - Modular wrap-around arithmetic.
  - ovf is tied to 0.

Test Plan:
1. Transpose latency (N=3, W=32): A=0..8 row-major, op 0 -> R = 0 3 6 / 1 4 7 / 2 5 8; busy high exactly 9 cycles; done pulses once.
2. Multiply: A=B=0..8, op 3 -> R = 15 18 21 / 42 54 66 / 69 90 111; busy high exactly 27 cycles.
3. Signed subtract: A=0,2,2,3,4,8,6,17,18 and B=10,11,12,3,4,5,6,7,0, op 2 -> R = -10 -9 -10 / 0 0 3 / 0 10 18.
4. Scalar and illegal op: A=0..8, op 4 with k=2 -> R = 0 2 4 ... 16. Then op 6 -> done after 1 cycle, err=1, R unchanged.
5. Overflow (W=8): A[0]=B[0]=100, op 1 -> R[0] = -56 with ovf=0 (macro off), or R[0] = 127 with ovf=1 (macro on).
6. Interruptions: op_start pulsed during op 3 is ignored and the result is still correct. Asserting reset_n=0 mid-multiply clears R, busy and done within the same cycle, with no done pulse.

Source files
------------

// File: rtl/matrix_alu_param.sv
// Parametrised N x N signed matrix ALU: A, B operands, R result, one step per cycle.
// Optional saturating arithmetic and ovf flag: define MATRIX_ALU_SATURATE_EN.
module matrix_alu_param #(
    parameter int N  = 3,
    parameter int W  = 32,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          wr_en,
    input  logic          wr_sel,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_data,
    input  logic          op_start,
    input  logic [2:0]    op_code,
    input  logic [W-1:0]  scalar,
    input  logic [AW-1:0] rd_addr,
    output logic [W-1:0]  rd_data,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic          ovf
);

    localparam int NN = N * N;
    localparam int IW = $clog2(NN);
    localparam int CW = $clog2(N);
    localparam logic [AW:0]   NN_A = (AW + 1)'(NN);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    localparam logic [2:0] OP_TR  = 3'd0;
    localparam logic [2:0] OP_ADD = 3'd1;
    localparam logic [2:0] OP_SUB = 3'd2;
    localparam logic [2:0] OP_MUL = 3'd3;
    localparam logic [2:0] OP_SCL = 3'd4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

`ifdef MATRIX_ALU_SATURATE_EN
    localparam logic [W-1:0] MAXV = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] MINV = {1'b1, {(W-1){1'b0}}};

    // Returns {clamped, value}; clamps to the signed W-bit range.
    function automatic logic [W:0] f_add(
        input logic [W-1:0] x,
        input logic [W-1:0] y,
        input logic         sub
    );
        logic [W:0] s;
        if (sub) s = {x[W-1], x} - {y[W-1], y};
        else     s = {x[W-1], x} + {y[W-1], y};
        if (s[W] != s[W-1])
            return {1'b1, (s[W] ? MINV : MAXV)};
        return {1'b0, s[W-1:0]};
    endfunction

    function automatic logic [W:0] f_mul(
        input logic [W-1:0] x,
        input logic [W-1:0] y
    );
        logic signed [2*W-1:0] p;
        logic [W:0]            hi;
        p  = $signed(x) * $signed(y);
        hi = p[2*W-1:W-1];
        if (hi != '0 && hi != '1)
            return {1'b1, (p[2*W-1] ? MINV : MAXV)};
        return {1'b0, p[W-1:0]};
    endfunction
`else
    // Modular arithmetic: the clamp bit is always 0.
    function automatic logic [W:0] f_add(
        input logic [W-1:0] x,
        input logic [W-1:0] y,
        input logic         sub
    );
        logic [W-1:0] s;
        if (sub) s = x - y;
        else     s = x + y;
        return {1'b0, s};
    endfunction

    function automatic logic [W:0] f_mul(
        input logic [W-1:0] x,
        input logic [W-1:0] y
    );
        logic [W-1:0] p;
        p = x * y;
        return {1'b0, p};
    endfunction
`endif

    function automatic logic [IW-1:0] f_idx(
        input logic [CW-1:0] r,
        input logic [CW-1:0] c
    );
        return IW'(r) * IW'(N) + IW'(c);
    endfunction

    state_t        state_q, state_d;
    logic [2:0]    op_q, op_d;
    logic [W-1:0]  scal_q, scal_d;
    logic [CW-1:0] i_q, i_d;
    logic [CW-1:0] j_q, j_d;
    logic [CW-1:0] k_q, k_d;
    logic [W-1:0]  acc_q, acc_d;
    logic          err_q, err_d;
    logic          ovf_q, ovf_d;
    logic [W-1:0]  rd_data_q, rd_data_d;
    logic [W-1:0]  a_q [NN];
    logic [W-1:0]  a_d [NN];
    logic [W-1:0]  b_q [NN];
    logic [W-1:0]  b_d [NN];
    logic [W-1:0]  r_q [NN];
    logic [W-1:0]  r_d [NN];

    logic [W:0]    t0, t1;
    logic [W-1:0]  res;
    logic          clamp;
    logic          wr_r;
    logic          last;
    logic [IW-1:0] e_ij, e_ji, e_ik, e_kj;

    // Next-state: operand writes, command decode, one datapath step per RUN cycle.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        scal_d    = scal_q;
        i_d       = i_q;
        j_d       = j_q;
        k_d       = k_q;
        acc_d     = acc_q;
        err_d     = err_q;
        ovf_d     = ovf_q;
        a_d       = a_q;
        b_d       = b_q;
        r_d       = r_q;
        t0        = '0;
        t1        = '0;
        res       = '0;
        clamp     = 1'b0;
        wr_r      = 1'b0;
        last      = 1'b0;
        e_ij      = f_idx(i_q, j_q);
        e_ji      = f_idx(j_q, i_q);
        e_ik      = f_idx(i_q, k_q);
        e_kj      = f_idx(k_q, j_q);

        if ({1'b0, rd_addr} < NN_A)
            rd_data_d = r_q[rd_addr[IW-1:0]];
        else
            rd_data_d = '0;

        unique case (state_q)
            S_IDLE: begin
                if (wr_en && ({1'b0, wr_addr} < NN_A)) begin
                    if (wr_sel) b_d[wr_addr[IW-1:0]] = wr_data;
                    else        a_d[wr_addr[IW-1:0]] = wr_data;
                end
                if (op_start) begin
                    if (op_code <= OP_SCL) begin
                        state_d = S_RUN;
                        op_d    = op_code;
                        scal_d  = scalar;
                        i_d     = '0;
                        j_d     = '0;
                        k_d     = '0;
                        acc_d   = '0;
                        err_d   = 1'b0;
                        ovf_d   = 1'b0;
                    end else begin
                        state_d = S_DONE;
                        err_d   = 1'b1;
                    end
                end
            end
            S_RUN: begin
                unique case (op_q)
                    OP_TR: begin
                        res  = a_q[e_ji];
                        wr_r = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        t0    = f_add(a_q[e_ij], b_q[e_ij],
                                      op_q == OP_SUB);
                        res   = t0[W-1:0];
                        clamp = t0[W];
                        wr_r  = 1'b1;
                    end
                    OP_SCL: begin
                        t0    = f_mul(scal_q, a_q[e_ij]);
                        res   = t0[W-1:0];
                        clamp = t0[W];
                        wr_r  = 1'b1;
                    end
                    OP_MUL: begin
                        t0 = f_mul(a_q[e_ik], b_q[e_kj]);
                        if (k_q == '0) begin
                            res   = t0[W-1:0];
                            clamp = t0[W];
                        end else begin
                            t1    = f_add(acc_q, t0[W-1:0], 1'b0);
                            res   = t1[W-1:0];
                            clamp = t0[W] | t1[W];
                        end
                        acc_d = res;
                        wr_r  = (k_q == LAST);
                    end
                    default: ;
                endcase

                if (wr_r) r_d[e_ij] = res;
                ovf_d = ovf_q | clamp;

                last = (i_q == LAST) && (j_q == LAST) &&
                       (op_q != OP_MUL || k_q == LAST);

                if (op_q == OP_MUL && k_q != LAST) begin
                    k_d = k_q + 1'b1;
                end else begin
                    k_d = '0;
                    if (j_q != LAST) begin
                        j_d = j_q + 1'b1;
                    end else begin
                        j_d = '0;
                        i_d = i_q + 1'b1;
                    end
                end

                if (last) state_d = S_DONE;
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State registers; reset clears matrices, flags and aborts any operation.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            op_q      <= '0;
            scal_q    <= '0;
            i_q       <= '0;
            j_q       <= '0;
            k_q       <= '0;
            acc_q     <= '0;
            err_q     <= 1'b0;
            ovf_q     <= 1'b0;
            rd_data_q <= '0;
            for (int e = 0; e < NN; e++) begin
                a_q[e] <= '0;
                b_q[e] <= '0;
                r_q[e] <= '0;
            end
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            scal_q    <= scal_d;
            i_q       <= i_d;
            j_q       <= j_d;
            k_q       <= k_d;
            acc_q     <= acc_d;
            err_q     <= err_d;
            ovf_q     <= ovf_d;
            rd_data_q <= rd_data_d;
            a_q       <= a_d;
            b_q       <= b_d;
            r_q       <= r_d;
        end
    end

    assign busy    = (state_q == S_RUN);
    assign done    = (state_q == S_DONE);
    assign err     = err_q;
    assign ovf     = ovf_q;
    assign rd_data = rd_data_q;

endmodule

// File: tb/tb_matrix_alu_param.sv
// Scoreboard bench for matrix_alu_param: 3x3/32-bit main instance,
// plus a 2x2/8-bit instance for wrap/saturation behaviour.
module tb_matrix_alu_param;

    localparam int N  = 3;
    localparam int W  = 32;
    localparam int AW = 4;
    localparam int NN = 9;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          wr_en, wr_sel;
    logic [AW-1:0] wr_addr;
    logic [W-1:0]  wr_data;
    logic          op_start;
    logic [2:0]    op_code;
    logic [W-1:0]  scalar;
    logic [AW-1:0] rd_addr;
    logic [W-1:0]  rd_data;
    logic          busy, done, err, ovf;

    logic          wr_en8, wr_sel8;
    logic [1:0]    wr_addr8;
    logic [7:0]    wr_data8;
    logic          op_start8;
    logic [2:0]    op_code8;
    logic [7:0]    scalar8;
    logic [1:0]    rd_addr8;
    logic [7:0]    rd_data8;
    logic          busy8, done8, err8, ovf8;

    int checks = 0;
    int passed = 0;
    logic [W-1:0] sb[$];
    int ma[NN];
    int mb[NN];

    matrix_alu_param #(.N(N), .W(W), .AW(AW)) dut (
        .clk(clk), .reset_n(reset_n),
        .wr_en(wr_en), .wr_sel(wr_sel),
        .wr_addr(wr_addr), .wr_data(wr_data),
        .op_start(op_start), .op_code(op_code),
        .scalar(scalar), .rd_addr(rd_addr),
        .rd_data(rd_data), .busy(busy),
        .done(done), .err(err), .ovf(ovf)
    );

    matrix_alu_param #(.N(2), .W(8), .AW(2)) dut8 (
        .clk(clk), .reset_n(reset_n),
        .wr_en(wr_en8), .wr_sel(wr_sel8),
        .wr_addr(wr_addr8), .wr_data(wr_data8),
        .op_start(op_start8), .op_code(op_code8),
        .scalar(scalar8), .rd_addr(rd_addr8),
        .rd_data(rd_data8), .busy(busy8),
        .done(done8), .err(err8), .ovf(ovf8)
    );

    always #5 clk = ~clk;

    task automatic load_mats();
        for (int e = 0; e < NN; e++) begin
            @(negedge clk);
            wr_en = 1'b1; wr_sel = 1'b0;
            wr_addr = AW'(e); wr_data = W'(ma[e]);
            @(negedge clk);
            wr_sel = 1'b1; wr_data = W'(mb[e]);
        end
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic run_op(input logic [2:0] code,
                          input logic [W-1:0] k,
                          input int exp_busy,
                          input string name);
        int cnt;
        @(negedge clk);
        op_start = 1'b1; op_code = code; scalar = k;
        @(negedge clk);
        op_start = 1'b0;
        cnt = 0;
        while (busy === 1'b1 && cnt < 1000) begin
            cnt++;
            @(negedge clk);
        end
        checks++;
        if (cnt !== exp_busy)
            $display("FAIL %s busy_cycles: got %0d expected %0d", name, cnt, exp_busy);
        else passed++;
        checks++;
        if (done !== 1'b1)
            $display("FAIL %s done_pulse: got %b expected 1", name, done);
        else passed++;
        @(negedge clk);
        checks++;
        if (done !== 1'b0)
            $display("FAIL %s done_width: got %b expected 0", name, done);
        else passed++;
    endtask

    task automatic check_r(input string name);
        for (int e = 0; e < NN; e++) begin
            logic [W-1:0] exp;
            @(negedge clk);
            rd_addr = AW'(e);
            @(negedge clk);
            exp = (sb.size() > 0) ? sb.pop_front() : 'x;
            checks++;
            if (rd_data !== exp)
                $display("FAIL %s R[%0d]: got %0d expected %0d",
                         name, e, $signed(rd_data), $signed(exp));
            else passed++;
        end
    endtask

    task automatic push_mul();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                int s;
                s = 0;
                for (int k = 0; k < N; k++)
                    s += ma[i*N+k] * mb[k*N+j];
                sb.push_back(W'(s));
            end
    endtask

    task automatic push_tr();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                sb.push_back(W'(ma[j*N+i]));
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, err, ovf} !== 4'b0)
            $display("FAIL reset flags: got %b expected 0000", {busy, done, err, ovf});
        else passed++;
        checks++;
        if (rd_data !== '0)
            $display("FAIL reset rd_data: got %0d expected 0", rd_data);
        else passed++;
        checks++;
        if ({busy8, done8, err8, ovf8, rd_data8} !== 12'b0)
            $display("FAIL reset dut8: got %h expected 0", {busy8, done8, err8, ovf8, rd_data8});
        else passed++;
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_transpose();
        for (int e = 0; e < NN; e++) begin ma[e] = e; mb[e] = 0; end
        load_mats();
        push_tr();
        run_op(3'd0, '0, 9, "transpose");
        check_r("transpose");
    endtask

    task automatic test_multiply();
        for (int e = 0; e < NN; e++) begin ma[e] = e; mb[e] = e; end
        load_mats();
        push_mul();
        run_op(3'd3, '0, 27, "multiply");
        check_r("multiply");
    endtask

    task automatic test_subtract();
        int ra[NN] = '{0, 2, 2, 3, 4, 8, 6, 17, 18};
        int rb[NN] = '{10, 11, 12, 3, 4, 5, 6, 7, 0};
        int rr[NN] = '{-10, -9, -10, 0, 0, 3, 0, 10, 18};
        for (int e = 0; e < NN; e++) begin
            ma[e] = ra[e]; mb[e] = rb[e];
        end
        load_mats();
        for (int e = 0; e < NN; e++) sb.push_back(W'(rr[e]));
        run_op(3'd2, '0, 9, "subtract");
        check_r("subtract");
    endtask

    task automatic test_scalar_illegal();
        for (int e = 0; e < NN; e++) begin ma[e] = e; mb[e] = 5; end
        load_mats();
        for (int e = 0; e < NN; e++) sb.push_back(W'(2 * e));
        run_op(3'd4, 32'd2, 9, "scalar");
        check_r("scalar");
        @(negedge clk);
        rd_addr = 4'd9;
        @(negedge clk);
        checks++;
        if (rd_data !== '0)
            $display("FAIL rd_oob: got %0d expected 0", rd_data);
        else passed++;
        for (int e = 0; e < NN; e++) sb.push_back(W'(2 * e));
        run_op(3'd6, '0, 0, "illegal");
        checks++;
        if (err !== 1'b1)
            $display("FAIL illegal err: got %b expected 1", err);
        else passed++;
        check_r("illegal_keep");
        for (int e = 0; e < NN; e++) sb.push_back(W'(e + 5));
        run_op(3'd1, '0, 9, "add");
        checks++;
        if (err !== 1'b0)
            $display("FAIL err_clear: got %b expected 0", err);
        else passed++;
        check_r("add");
    endtask

    task automatic test_overflow();
        int cnt;
        logic [7:0] exp_r;
        logic       exp_o;
`ifdef MATRIX_ALU_SATURATE_EN
        exp_r = 8'd127; exp_o = 1'b1;
`else
        exp_r = 8'hC8;  exp_o = 1'b0;
`endif
        @(negedge clk);
        wr_en8 = 1'b1; wr_sel8 = 1'b0; wr_addr8 = 2'd0; wr_data8 = 8'd100;
        @(negedge clk);
        wr_sel8 = 1'b1;
        @(negedge clk);
        wr_en8 = 1'b0; op_start8 = 1'b1; op_code8 = 3'd1;
        @(negedge clk);
        op_start8 = 1'b0;
        cnt = 0;
        while (busy8 === 1'b1 && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
        checks++;
        if (cnt !== 4)
            $display("FAIL ovf8 busy_cycles: got %0d expected 4", cnt);
        else passed++;
        rd_addr8 = 2'd0;
        @(negedge clk);
        checks++;
        if (rd_data8 !== exp_r)
            $display("FAIL ovf8 R[0]: got %0d expected %0d", $signed(rd_data8), $signed(exp_r));
        else passed++;
        checks++;
        if (ovf8 !== exp_o)
            $display("FAIL ovf8 flag: got %b expected %b", ovf8, exp_o);
        else passed++;
    endtask

    task automatic test_interrupt();
        int cnt;
        int pulses;
        for (int e = 0; e < NN; e++) begin ma[e] = e; mb[e] = e; end
        load_mats();
        push_mul();
        @(negedge clk);
        op_start = 1'b1; op_code = 3'd3;
        @(negedge clk);
        op_start = 1'b0;
        cnt = 0;
        while (busy === 1'b1 && cnt < 1000) begin
            cnt++;
            if (cnt == 5) begin
                op_start = 1'b1; op_code = 3'd0;
                wr_en = 1'b1; wr_sel = 1'b0;
                wr_addr = '0; wr_data = 32'd99;
            end else begin
                op_start = 1'b0; wr_en = 1'b0;
            end
            @(negedge clk);
        end
        op_start = 1'b0; wr_en = 1'b0;
        checks++;
        if (cnt !== 27)
            $display("FAIL intr busy_cycles: got %0d expected 27", cnt);
        else passed++;
        checks++;
        if (done !== 1'b1)
            $display("FAIL intr done: got %b expected 1", done);
        else passed++;
        check_r("intr_mul");
        push_tr();
        run_op(3'd0, '0, 9, "intr_tr");
        check_r("intr_tr");

        @(negedge clk);
        op_start = 1'b1; op_code = 3'd3;
        @(negedge clk);
        op_start = 1'b0;
        repeat (10) @(negedge clk);
        checks++;
        if (busy !== 1'b1)
            $display("FAIL midrun busy: got %b expected 1", busy);
        else passed++;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({busy, done} !== 2'b00 || rd_data !== '0)
            $display("FAIL async_reset: got busy/done %b rd %0d expected 00 0", {busy, done}, rd_data);
        else passed++;
        @(negedge clk);
        reset_n = 1'b1;
        pulses = 0;
        repeat (30) begin
            @(negedge clk);
            if (done === 1'b1) pulses++;
        end
        checks++;
        if (pulses !== 0)
            $display("FAIL abort done_pulses: got %0d expected 0", pulses);
        else passed++;
        for (int e = 0; e < NN; e++) sb.push_back('0);
        check_r("reset_clear");
    endtask

    initial begin
        reset_n = 1'b0;
        wr_en = 1'b0; wr_sel = 1'b0; wr_addr = '0; wr_data = '0;
        op_start = 1'b0; op_code = '0; scalar = '0; rd_addr = '0;
        wr_en8 = 1'b0; wr_sel8 = 1'b0; wr_addr8 = '0; wr_data8 = '0;
        op_start8 = 1'b0; op_code8 = '0; scalar8 = '0; rd_addr8 = '0;
        test_reset();
        test_transpose();
        test_multiply();
        test_subtract();
        test_scalar_illegal();
        test_overflow();
        test_interrupt();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
